// File: rtl/fc_requant.sv
// fc_requant: bias add, round/shift, ReLU+saturate and FIFO-buffer FC accumulator results
module fc_requant #(
  parameter int gen_width = 21,
  parameter int out_width = 8,
  parameter int shift = 8,
  parameter int n_neuron = 10,
  parameter int fifo_depth = 4,
  localparam int aw = $clog2(n_neuron)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 acc_done,
  input  logic [gen_width-1:0] result,
  input  logic                 bias_wr_en,
  input  logic [aw-1:0]        bias_wr_addr,
  input  logic [gen_width-1:0] bias_wr_data,
  output logic [out_width-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [aw-1:0]        neuron_idx,
  output logic                 layer_done,
  output logic                 ovf
);
  localparam int pw = $clog2(fifo_depth);
  localparam logic [gen_width+1:0] half = (gen_width+2)'(1) << (shift - 1);
  logic [gen_width-1:0] bias [n_neuron];
  logic signed [gen_width:0] sum1;
  logic valid1;
  logic signed [gen_width+1:0] rnd, r;
  logic [out_width-1:0] din;
  logic [out_width-1:0] mem [fifo_depth];
  logic [pw:0] wptr, rptr, cnt;
  logic [aw-1:0] pcnt;
  logic full, pop, wr;
  always_comb begin
    rnd = {sum1[gen_width], sum1} + half;
    r = rnd >>> shift;
    din = r[gen_width+1] ? '0 : |r[gen_width:out_width] ? '1 : r[out_width-1:0];
    cnt = wptr - rptr;
    out_valid = cnt != '0;
    full = cnt == (pw+1)'(fifo_depth);
    pop = out_valid && out_ready;
    wr = valid1 && (!full || pop);
  end
  always_ff @(posedge clk)
    if (wr) mem[wptr[pw-1:0]] <= din;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < n_neuron; i++) bias[i] <= '0;
      sum1 <= '0;
      valid1 <= 1'b0;
      neuron_idx <= '0;
      wptr <= '0;
      rptr <= '0;
      pcnt <= '0;
      out_data <= '0;
      layer_done <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (bias_wr_en && bias_wr_addr < aw'(n_neuron)) bias[bias_wr_addr] <= bias_wr_data;
      valid1 <= acc_done;
      if (acc_done) begin
        sum1 <= {result[gen_width-1], result} + {bias[neuron_idx][gen_width-1], bias[neuron_idx]};
        neuron_idx <= neuron_idx == aw'(n_neuron - 1) ? '0 : neuron_idx + 1'b1;
      end
      if (wr) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        pcnt <= pcnt == aw'(n_neuron - 1) ? '0 : pcnt + 1'b1;
      end
      layer_done <= pop && pcnt == aw'(n_neuron - 1);
      if (valid1 && !wr) ovf <= 1'b1;
      // out_data is a registered copy of the head: refill from the next slot on pop, or take the bypass when the head is being replaced by the incoming push
      if (pop && cnt != (pw+1)'(1)) out_data <= mem[pw'(rptr + 1'b1)];
      else if (wr && (!out_valid || pop)) out_data <= din;
    end
endmodule
